// File: rtl/pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pulse_scheduler
// Description : Clock-counted astable pulse generator. Holds programmable
//               high/low durations and a burst length, accepts settings via
//               a valid/ready handshake, and produces a finite burst or a
//               continuous pulse train until stopped.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_scheduler #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_ON  = 353,
  parameter int unsigned DEF_OFF = 346
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_off,
  input  logic [7:0]       cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] c_def_on  = CNT_W'(DEF_ON);
  localparam logic [CNT_W-1:0] c_def_off = CNT_W'(DEF_OFF);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [7:0]       pulses_done_q, pulses_done_d;
  logic [CNT_W-1:0] on_len_q, on_len_d;
  logic [CNT_W-1:0] off_len_q, off_len_d;
  logic [7:0]       count_len_q, count_len_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             w_cfg_accept;
  logic [CNT_W-1:0] w_cfg_on_clamped;
  logic [CNT_W-1:0] w_cfg_off_clamped;
  logic [CNT_W-1:0] w_run_on_len;
  logic             w_last_cycle;
  logic [7:0]       w_pulses_next;

  // Handshake decode and zero-duration clamping of the incoming config.
  always_comb begin
    w_cfg_accept      = cfg_valid && (state_q == ST_IDLE);
    w_cfg_on_clamped  = (cfg_on  == '0) ? c_one : cfg_on;
    w_cfg_off_clamped = (cfg_off == '0) ? c_one : cfg_off;
    // A config accepted on the start edge must govern that very run.
    w_run_on_len      = w_cfg_accept ? w_cfg_on_clamped : on_len_q;
    w_last_cycle      = (dur_cnt_q <= c_one);
    w_pulses_next     = pulses_done_q + 8'd1;
  end

  // Config register update; only legal while idle.
  always_comb begin
    on_len_d    = on_len_q;
    off_len_d   = off_len_q;
    count_len_d = count_len_q;
    if (w_cfg_accept) begin
      on_len_d    = w_cfg_on_clamped;
      off_len_d   = w_cfg_off_clamped;
      count_len_d = cfg_count;
    end
  end

  // Next-state, duration counter and burst counter; stop overrides everything.
  always_comb begin
    state_d       = state_q;
    dur_cnt_d     = dur_cnt_q;
    pulses_done_d = pulses_done_q;
    done_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d       = ST_ON;
          dur_cnt_d     = w_run_on_len;
          pulses_done_d = 8'd0;
        end
      end
      ST_ON: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (w_last_cycle) begin
          state_d   = ST_OFF;
          dur_cnt_d = off_len_q;
        end else begin
          dur_cnt_d = dur_cnt_q - c_one;
        end
      end
      ST_OFF: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (w_last_cycle) begin
          // In continuous mode the count simply wraps and is never compared.
          pulses_done_d = w_pulses_next;
          if ((count_len_q != 8'd0) && (w_pulses_next == count_len_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_ON;
            dur_cnt_d = on_len_q;
          end
        end else begin
          dur_cnt_d = dur_cnt_q - c_one;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they track it exactly.
  always_comb begin
    pulse_d = (state_d == ST_ON);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and config registers with asynchronous return to defaults.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      dur_cnt_q     <= '0;
      pulses_done_q <= 8'd0;
      on_len_q      <= c_def_on;
      off_len_q     <= c_def_off;
      count_len_q   <= 8'd0;
      pulse_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dur_cnt_q     <= dur_cnt_d;
      pulses_done_q <= pulses_done_d;
      on_len_q      <= on_len_d;
      off_len_q     <= off_len_d;
      count_len_q   <= count_len_d;
      pulse_q       <= pulse_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // Decoded from state only, so an upstream master sees no input dependency.
  assign cfg_ready = (state_q == ST_IDLE);

`ifndef SYNTHESIS
  // Output consistency: a high pulse is always part of a busy sequence, and
  // completion coincides with the return to idle.
  a_pulse_implies_busy : assert property (@(posedge clk) disable iff (!rst)
    pulse_q |-> busy_q);
  a_done_implies_idle : assert property (@(posedge clk) disable iff (!rst)
    done_q |-> (!busy_q && cfg_ready));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_scheduler
// Description : Scoreboard bench for pulse_scheduler. The driver pushes the
//               expected {pulse,busy,done,cfg_ready} for every cycle it
//               drives; an independent monitor pops and compares one entry
//               shortly after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_scheduler;

  localparam int CNT_W = 16;

  // Expected output vectors, ordered {pulse, busy, done, cfg_ready}.
  localparam logic [3:0] E_IDLE = 4'b0001;
  localparam logic [3:0] E_ON   = 4'b1100;
  localparam logic [3:0] E_OFF  = 4'b0100;
  localparam logic [3:0] E_DONE = 4'b0011;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_on;
  logic [CNT_W-1:0] cfg_off;
  logic [7:0]       cfg_count;
  logic             start;
  logic             stop;
  logic             pulse;
  logic             busy;
  logic             done;

  typedef struct {
    logic [3:0] e;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  pulse_scheduler #(
    .CNT_W  (CNT_W),
    .DEF_ON (353),
    .DEF_OFF(346)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_on   (cfg_on),
    .cfg_off  (cfg_off),
    .cfg_count(cfg_count),
    .start    (start),
    .stop     (stop),
    .pulse    (pulse),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected vector is consumed per rising edge.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        n_vec++;
        if ({pulse, busy, done, cfg_ready} !== it.e) begin
          n_err++;
          $display("FAIL %s @%0t: pulse/busy/done/ready got %b required %b",
                   it.nm, $time, {pulse, busy, done, cfg_ready}, it.e);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of control inputs and record the response expected
  // after the next rising edge.
  task automatic cyc(input logic st, input logic sp, input logic [3:0] e,
                     input string nm);
    @(negedge clk);
    start     = st;
    stop      = sp;
    cfg_valid = 1'b0;
    sb_q.push_back('{e, nm});
  endtask

  // Present a config for one cycle, optionally with start.
  task automatic cfg_cyc(input logic [CNT_W-1:0] on, input logic [CNT_W-1:0] off,
                         input logic [7:0] cnt, input logic st,
                         input logic [3:0] e, input string nm);
    @(negedge clk);
    cfg_on    = on;
    cfg_off   = off;
    cfg_count = cnt;
    cfg_valid = 1'b1;
    start     = st;
    stop      = 1'b0;
    sb_q.push_back('{e, nm});
  endtask

  // Expected pulse train of n pulses; skip_first leaves out the first ON
  // cycle, which the start cycle already accounts for.
  task automatic pulses(input int on, input int off, input int n,
                        input bit skip_first, input string nm);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < on; c++) begin
        if (!(skip_first && p == 0 && c == 0)) cyc(1'b0, 1'b0, E_ON, nm);
      end
      for (int c = 0; c < off; c++) cyc(1'b0, 1'b0, E_OFF, nm);
    end
  endtask

  // Short reset pulse entirely between rising edges.
  task automatic async_reset(input string nm);
    @(negedge clk);
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    rst       = 1'b0;
    #2;
    rst       = 1'b1;
    sb_q.push_back('{E_IDLE, nm});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_on    = '0;
    cfg_off   = '0;
    cfg_count = 8'd0;
    start     = 1'b0;
    stop      = 1'b0;

    // Held reset, then release.
    cyc(1'b0, 1'b0, E_IDLE, "reset_held");
    cyc(1'b0, 1'b0, E_IDLE, "reset_held");
    rst = 1'b1;
    cyc(1'b0, 1'b0, E_IDLE, "reset_release");

    // Default-config run interrupted by reset mid-ON.
    cyc(1'b1, 1'b0, E_ON, "def_start");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, E_ON, "def_on");
    async_reset("rst_mid_def_on");
    cyc(1'b0, 1'b0, E_IDLE, "after_rst");

    // Custom config, then reset must restore defaults.
    cfg_cyc(16'd5, 16'd4, 8'd0, 1'b0, E_IDLE, "pre_cfg");
    cyc(1'b1, 1'b0, E_ON, "pre_start");
    cyc(1'b0, 1'b0, E_ON, "pre_on");
    cyc(1'b0, 1'b0, E_ON, "pre_on");
    async_reset("rst_mid_cfg_on");
    cyc(1'b0, 1'b0, E_IDLE, "after_rst2");
    cyc(1'b1, 1'b0, E_ON, "dflt_start");
    pulses(353, 346, 1, 1'b1, "dflt_353_346");
    cyc(1'b0, 1'b0, E_ON, "dflt_p2");
    cyc(1'b0, 1'b1, E_IDLE, "dflt_stop");

    // Finite burst: on=3 off=2 count=2.
    cfg_cyc(16'd3, 16'd2, 8'd2, 1'b0, E_IDLE, "burst_cfg");
    cyc(1'b1, 1'b0, E_ON, "burst_start");
    pulses(3, 2, 2, 1'b1, "burst");
    cyc(1'b0, 1'b0, E_DONE, "burst_done");
    cyc(1'b0, 1'b0, E_IDLE, "burst_idle");

    // Continuous run past the burst-counter wrap, stopped mid-ON.
    cfg_cyc(16'd2, 16'd1, 8'd0, 1'b0, E_IDLE, "cont_cfg");
    cyc(1'b1, 1'b0, E_ON, "cont_start");
    pulses(2, 1, 300, 1'b1, "cont");
    cyc(1'b0, 1'b0, E_ON, "cont_p301");
    cyc(1'b0, 1'b1, E_IDLE, "cont_stop");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, E_IDLE, "cont_idle");

    // Zero durations clamp to 1; config during busy is ignored; start held
    // high through done restarts immediately.
    cfg_cyc(16'd0, 16'd0, 8'd3, 1'b0, E_IDLE, "zero_cfg");
    cyc(1'b1, 1'b0, E_ON, "zero_start");
    cfg_cyc(16'd9, 16'd9, 8'd1, 1'b1, E_OFF, "cfg_busy_ignored");
    cfg_cyc(16'd9, 16'd9, 8'd1, 1'b1, E_ON, "cfg_busy_ignored");
    cfg_cyc(16'd9, 16'd9, 8'd1, 1'b1, E_OFF, "cfg_busy_ignored");
    cyc(1'b1, 1'b0, E_ON, "start_busy_ignored");
    cyc(1'b1, 1'b0, E_OFF, "start_busy_ignored");
    cyc(1'b1, 1'b0, E_DONE, "zero_done");
    cyc(1'b1, 1'b0, E_ON, "restart_after_done");
    pulses(1, 1, 3, 1'b1, "zero_run2");
    cyc(1'b0, 1'b0, E_DONE, "zero_done2");
    cyc(1'b0, 1'b0, E_IDLE, "zero_idle");

    // start and stop together in idle.
    cyc(1'b1, 1'b1, E_IDLE, "start_stop_idle");
    cyc(1'b0, 1'b0, E_IDLE, "start_stop_idle2");

    // stop on the final OFF cycle suppresses done.
    cfg_cyc(16'd2, 16'd2, 8'd1, 1'b0, E_IDLE, "last_off_cfg");
    cyc(1'b1, 1'b0, E_ON, "last_off_start");
    cyc(1'b0, 1'b0, E_ON, "last_off_on");
    cyc(1'b0, 1'b0, E_OFF, "last_off_off");
    cyc(1'b0, 1'b0, E_OFF, "last_off_off");
    cyc(1'b0, 1'b1, E_IDLE, "stop_last_off");
    cyc(1'b0, 1'b0, E_IDLE, "stop_last_off_idle");

    // Config accepted on the start edge is used for that run.
    cfg_cyc(16'd1, 16'd3, 8'd1, 1'b1, E_ON, "cfg_and_start");
    cyc(1'b0, 1'b0, E_OFF, "cfg_and_start_off");
    cyc(1'b0, 1'b0, E_OFF, "cfg_and_start_off");
    cyc(1'b0, 1'b0, E_OFF, "cfg_and_start_off");
    cyc(1'b0, 1'b0, E_DONE, "cfg_and_start_done");
    cyc(1'b0, 1'b0, E_IDLE, "final_idle");

    // Let the monitor consume what remains, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_scheduler.md
# pulse_scheduler

Synthesizable, clock-counted replacement for the delay-based astable pulse generator in the lab timer designs. It holds programmable high/low durations and a pulse count, accepts new settings through a valid/ready handshake, and runs the output as a finite burst or continuously until stopped. It sits between the lab's control logic (switches/FSM) and whatever consumes the timer pulse.

## Interface
- CNT_W, 16: width of duration counters and duration config fields.
- DEF_ON, 353: reset-value high duration in clk cycles ((1+50)·10·0.693, truncated).
- DEF_OFF, 346: reset-value low duration in clk cycles (50·10·0.693, truncated).

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  config presented.
- cfg_ready  output  1  block can accept config; high only in IDLE.
- cfg_on  input  CNT_W  high duration in cycles.
- cfg_off  input  CNT_W  low duration in cycles.
- cfg_count  input  8  pulses per burst; 0 = continuous.
- start  input  1  begin sequence (level sampled, acted on in IDLE only).
- stop  input  1  abort sequence.
- pulse  output  1  timer output, registered.
- busy  output  1  high in ON or OFF.
- done  output  1  one-cycle strobe when a finite burst completes.

## Operation
- Registers on_len, off_len, count_len; reset to DEF_ON, DEF_OFF, 0.
- Config accepted on the edge where cfg_valid && cfg_ready. cfg_on or cfg_off of 0 is stored as 1. cfg_valid while cfg_ready=0 is ignored, not queued.
- States: IDLE, ON, OFF.
- IDLE: pulse=0, busy=0, cfg_ready=1. If start && !stop: go to ON, load dur_cnt=on_len, clear pulses_done. cfg accept and start on the same edge: new config is used for that run.
- ON: pulse=1. dur_cnt decrements each cycle. On the last cycle (dur_cnt==1): go to OFF, load dur_cnt=off_len.
- OFF: pulse=0. dur_cnt decrements each cycle. On the last cycle, pulses_done is incremented (8-bit):
  - count_len≠0 and pulses_done+1==count_len: go to IDLE, assert done for 1 cycle.
  - Otherwise: go to ON, reload dur_cnt=on_len.
- Continuous mode (count_len=0): pulses_done wraps at 255 with no side effect, and the sequence never self-terminates.
- stop in ON or OFF: next state IDLE, pulse=0, done not asserted, and the partial pulse is truncated. stop has priority over every other transition, including the final-OFF-cycle done transition.
- start while busy: ignored. Holding start high in IDLE after done starts a new run on the next edge.
- rst low at any time: immediately IDLE, pulse=0, busy=0, done=0, cfg_ready=1, config back to defaults, counters cleared.

## Timing
- Start accepted at edge E: pulse=1 from E+1 for exactly on_len cycles, then 0 for exactly off_len cycles.
- Period is on_len+off_len cycles, with no dead cycles between pulses.
- done is high in the cycle after the last OFF cycle, coincident with busy=0 and cfg_ready=1.
- busy rises at E+1 and falls at the same edge as done rises, or on the edge after stop is sampled.
- All outputs are registered, with no combinational input-to-output paths, except cfg_ready, which is decoded from state only.

## Test plan
- Reset: assert rst=0 mid-ON with on=353 → pulse=0, busy=0, cfg_ready=1 asynchronously. After release, start runs with on=353, off=346.
- Burst: cfg on=3, off=2, count=2, then start at edge 0 → pulse high cycles 1–3 and 6–8, low cycles 4–5 and 9–10, done=1 in cycle 11 only, busy low from cycle 11.
- Continuous plus stop: on=2, off=1, count=0, run 300 pulses (past the pulses_done wrap), then stop in the middle of an ON phase → pulse=0 and busy=0 on the next cycle, done never asserted.
- Zero clamp and handshake: cfg on=0, off=0, count=3 → period 2 cycles, 3 pulses, then done. cfg_valid during busy with on=9 → cfg_ready=0 and the next run still uses on=1.
- Simultaneous events: start and stop high together in IDLE → stays IDLE. stop on the final OFF cycle of a burst → IDLE with no done. cfg accept and start on the same edge → new durations used.
